// File: rtl/ram_sp_arbiter_pkg.sv
// Shared definitions for the two-requester single-port RAM arbiter.
package ram_sp_arbiter_pkg;

  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmd  = 2'd1,
    StData = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the pointer.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_en,
  output logic       o_vld,
  output logic       o_id,
  output logic       o_ptr_nxt
);

  always_comb begin
    o_vld = i_en & (|i_req);
    if (i_req == 2'b11) begin
      o_id = i_ptr;
    end else begin
      o_id = i_req[1];
    end
    // Pointer moves only on a real grant, to the requester that lost.
    o_ptr_nxt = o_vld ? ~o_id : i_ptr;
  end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Round-robin controller sharing one single-port RAM between two requesters.
module ram_sp_arbiter
  import ram_sp_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rdata,
  output logic          o_busy,
  output logic          o_ram_rw_en,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_din,
  input  logic [DW-1:0] i_ram_dout
);

  state_e        r_state, w_state_nxt;
  logic          r_ptr, w_ptr_nxt;
  logic [1:0]    r_gnt, w_gnt_nxt;
  logic [1:0]    r_rvalid, w_rvalid_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_rw_en, w_rw_en_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_din, w_din_nxt;
  logic          r_owner, w_owner_nxt;
  logic          r_we, w_we_nxt;

  logic          w_arb_vld, w_arb_id;
  logic          w_we_sel;
  logic [AW-1:0] w_addr_sel;
  logic [DW-1:0] w_wdata_sel;

  rr_arb2 u_arb (
    .i_req     ({i_req1, i_req0}),
    .i_ptr     (r_ptr),
    .i_en      (r_state == StIdle),
    .o_vld     (w_arb_vld),
    .o_id      (w_arb_id),
    .o_ptr_nxt (w_ptr_nxt)
  );

  assign w_we_sel    = w_arb_id ? i_we1 : i_we0;
  assign w_addr_sel  = w_arb_id ? i_addr1 : i_addr0;
  assign w_wdata_sel = w_arb_id ? i_wdata1 : i_wdata0;

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = 2'b00;
    w_rvalid_nxt = 2'b00;
    w_rdata_nxt  = r_rdata;
    w_rw_en_nxt  = r_rw_en;
    w_addr_nxt   = r_addr;
    w_din_nxt    = r_din;
    w_owner_nxt  = r_owner;
    w_we_nxt     = r_we;
    unique case (r_state)
      StIdle: begin
        if (w_arb_vld) begin
          w_owner_nxt          = w_arb_id;
          w_we_nxt             = w_we_sel;
          w_addr_nxt           = w_addr_sel;
          w_din_nxt            = w_wdata_sel;
          w_rw_en_nxt          = ~w_we_sel;
          w_gnt_nxt[w_arb_id]  = 1'b1;
          w_state_nxt          = StCmd;
        end
      end
      StCmd: begin
        // The RAM acts on this edge; a write is done, a read needs its registered dout.
        if (r_we) begin
          w_rw_en_nxt = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StData;
        end
      end
      StData: begin
        w_rdata_nxt           = i_ram_dout;
        w_rvalid_nxt[r_owner] = 1'b1;
        w_state_nxt           = StIdle;
      end
      default: begin
        w_rw_en_nxt = 1'b1;
        w_state_nxt = StIdle;
      end
    endcase
    w_busy_nxt = (w_state_nxt != StIdle);
  end

  // Async reset pulls rw_en high at once so an in-flight write never lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_ptr    <= 1'b0;
      r_gnt    <= 2'b00;
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_rw_en  <= 1'b1;
      r_addr   <= '0;
      r_din    <= '0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rdata  <= w_rdata_nxt;
      r_busy   <= w_busy_nxt;
      r_rw_en  <= w_rw_en_nxt;
      r_addr   <= w_addr_nxt;
      r_din    <= w_din_nxt;
      r_owner  <= w_owner_nxt;
      r_we     <= w_we_nxt;
    end
  end

  assign o_gnt0      = r_gnt[0];
  assign o_gnt1      = r_gnt[1];
  assign o_rvalid0   = r_rvalid[0];
  assign o_rvalid1   = r_rvalid[1];
  assign o_rdata     = r_rdata;
  assign o_busy      = r_busy;
  assign o_ram_rw_en = r_rw_en;
  assign o_ram_addr  = r_addr;
  assign o_ram_din   = r_din;

endmodule
